// File: rtl/vga_scan_pkg.sv
// vga_scan_pkg: shared 800x600 VGA timing constants, control bundle type and pixel helper
package vga_scan_pkg;
  localparam int H_ACTIVE = 800;
  localparam int H_FP = 56;
  localparam int H_SYNC = 120;
  localparam int H_BP = 64;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 600;
  localparam int V_FP = 37;
  localparam int V_SYNC = 6;
  localparam int V_BP = 23;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam bit SYNC_POL = 1'b1;
  localparam int ADDR_W = 19;
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vga_ctl_t;
  function automatic logic [11:0] expand_rgb(input logic [5:0] c);
    return {c[5:4], c[5:4], c[3:2], c[3:2], c[1:0], c[1:0]};
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping position counter for one screen axis with active and sync window flags
// Ports: clk, rst_n (async, active-low), en (advance), last (at TOTAL-1),
//        active (cnt < ACTIVE), in_sync (SYNC_START <= cnt < SYNC_END)
module vga_axis_counter #(
  parameter int TOTAL = 1040,
  parameter int ACTIVE = 800,
  parameter int SYNC_START = 856,
  parameter int SYNC_END = 976,
  parameter int W = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic last,
  output logic active,
  output logic in_sync
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (en) cnt <= last ? '0 : cnt + 1'b1;
  assign last = cnt == W'(TOTAL - 1);
  assign active = cnt < W'(ACTIVE);
  assign in_sync = cnt >= W'(SYNC_START) && cnt < W'(SYNC_END);
endmodule

// File: rtl/vga_scan.sv
// vga_scan: VGA scan generator, one pixel every 2 clk, fetching from a 2-clk-latency frame buffer
// Ports: clk, rst_n (async, active-low); rd_addr frame-buffer address; rgb_in 2-2-2 pixel data
//        arriving 2 clk after rd_addr; hsync/vsync to monitor; vga_data 4-4-4 to DAC;
//        frame_start one-clk pulse when the scan wraps to pixel (0,0)
module vga_scan #(
  parameter int H_ACTIVE = vga_scan_pkg::H_ACTIVE,
  parameter int H_FP = vga_scan_pkg::H_FP,
  parameter int H_SYNC = vga_scan_pkg::H_SYNC,
  parameter int H_BP = vga_scan_pkg::H_BP,
  parameter int V_ACTIVE = vga_scan_pkg::V_ACTIVE,
  parameter int V_FP = vga_scan_pkg::V_FP,
  parameter int V_SYNC = vga_scan_pkg::V_SYNC,
  parameter int V_BP = vga_scan_pkg::V_BP,
  parameter bit SYNC_POL = vga_scan_pkg::SYNC_POL
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic [vga_scan_pkg::ADDR_W-1:0] rd_addr,
  input  logic [5:0]                      rgb_in,
  output logic                            hsync,
  output logic                            vsync,
  output logic [11:0]                     vga_data,
  output logic                            frame_start
);
  import vga_scan_pkg::*;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  logic pix_en, h_last, v_last, h_act, v_act, h_win, v_win, frame_wrap;
  vga_ctl_t raw, ctl_d;
  vga_axis_counter #(
    .TOTAL(HT), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP),
    .SYNC_END(H_ACTIVE + H_FP + H_SYNC), .W($clog2(HT))
  ) u_h (.clk, .rst_n, .en(pix_en), .last(h_last), .active(h_act), .in_sync(h_win));
  vga_axis_counter #(
    .TOTAL(VT), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP),
    .SYNC_END(V_ACTIVE + V_FP + V_SYNC), .W($clog2(VT))
  ) u_v (.clk, .rst_n, .en(pix_en & h_last), .last(v_last), .active(v_act), .in_sync(v_win));
  assign frame_wrap = pix_en & h_last & v_last;
  assign raw = '{h_win ? SYNC_POL : ~SYNC_POL, v_win ? SYNC_POL : ~SYNC_POL, h_act & v_act};
  // ctl_d lags the counters by one pixel, so it lines up with rgb_in for the same pixel;
  // rd_addr counts active pixels and saturates at the last one through the bottom blanking.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pix_en <= 1'b0;
      rd_addr <= '0;
      ctl_d <= '{~SYNC_POL, ~SYNC_POL, 1'b0};
      vga_data <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_en <= ~pix_en;
      frame_start <= frame_wrap;
      vga_data <= ctl_d.de ? expand_rgb(rgb_in) : 12'h000;
      if (pix_en) begin
        ctl_d <= raw;
        rd_addr <= frame_wrap ? '0 : (raw.de && rd_addr != ADDR_MAX) ? rd_addr + 1'b1 : rd_addr;
      end
    end
  assign hsync = ctl_d.hs;
  assign vsync = ctl_d.vs;
endmodule

// File: doc/vga_scan.md
VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 56 / 120 / 64, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_ACTIVE, default 600, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 37 / 6 / 23, vertical porch and sync widths in lines.
REQ-005 Parameter SYNC_POL, default 1, active level of hsync and vsync.
REQ-006 CLK  input  1  system clock, 100 MHz; the only clock.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 rd_addr  output  19  frame-buffer read address, row-major, H_ACTIVE words per line.
REQ-009 rgb_in  input  6  frame-buffer read data {r[1:0],g[1:0],b[1:0]}, valid 2 CLK after rd_addr.
REQ-010 hsync  output  1  horizontal sync to monitor.
REQ-011 vsync  output  1  vertical sync to monitor.
REQ-012 vga_data  output  12  {R[3:0],G[3:0],B[3:0]} to DAC.
REQ-013 frame_start  output  1  one-CLK pulse at start of each frame.

Function
REQ-014 Internal pix_en SHALL toggle every CLK, giving one pixel per 2 CLK (50 MHz); counters advance only on CLK edges where pix_en=1.
REQ-015 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL=1040) and wrap to 0; v_cnt SHALL increment when h_cnt wraps, range 0..V_TOTAL-1 (V_TOTAL=666), wrap to 0.
REQ-016 Raw de SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-017 Raw hsync SHALL equal SYNC_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (856..975), else ~SYNC_POL.
REQ-018 Raw vsync SHALL equal SYNC_POL iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (637..642), else ~SYNC_POL.
REQ-019 rd_addr SHALL equal v_cnt*H_ACTIVE+h_cnt for the pixel being fetched, produced by an incrementing register (no multiplier): +1 per active pixel, held during blanking, cleared to 0 at h_cnt=0,v_cnt=0.
REQ-020 hsync, vsync and de SHALL be delayed by exactly one pixel (2 CLK) so outputs align with rgb_in for the same pixel.
REQ-021 vga_data SHALL be registered: {r,r,g,g,b,b} bit-pair replication (e.g. rgb_in=6'b01_10_11 -> 12'h5AF) when delayed de=1, else 12'h000.
REQ-022 frame_start SHALL pulse high for one CLK on the pix_en edge where h_cnt and v_cnt both wrap to 0.
REQ-023 Line period SHALL be 2080 CLK; frame period 1,385,280 CLK; no cycle skipped or duplicated at wrap.
REQ-024 rd_addr SHALL never exceed H_ACTIVE*V_ACTIVE-1 (479,999).

Reset
REQ-025 While rst_n=0: h_cnt=0, v_cnt=0, pix_en=0, rd_addr=0, vga_data=0, frame_start=0, hsync=vsync=~SYNC_POL.
REQ-026 Reset assertion mid-line SHALL take effect immediately (asynchronous); release SHALL restart at pixel (0,0) with first counter advance on the second CLK edge after release.

Structure
REQ-027 Timing constants (H_*, V_*, totals, SYNC_POL) SHALL live in a shared package also used by the drawing stage for screen dimensions.
REQ-028 One sub-module SHALL be used: vga_axis_counter, a generic wrap counter with sync-window compare, instantiated for horizontal and vertical axes.

Verification
REQ-029 Reset held low 10 CLK -> hsync=vsync=0, vga_data=0, rd_addr=0, frame_start=0 throughout.
REQ-030 Release reset, run 1 line -> hsync high for 240 CLK starting 1712 CLK + 2 CLK pipeline after line start; period 2080 CLK.
REQ-031 Run 2 frames -> vsync high for 12,480 CLK per frame; frame_start pulses exactly twice, 1,385,280 CLK apart.
REQ-032 RAM model returning rgb_in=addr[5:0] with 2-CLK latency -> each displayed pixel (x,y) shows expansion of (y*800+x)[5:0]; vga_data=0 in every blanking pixel.
REQ-033 Monitor rd_addr over one frame -> 480,000 distinct increments 0..479,999, then 0 at next frame_start.
REQ-034 Assert rst_n low at h_cnt=400,v_cnt=300 -> outputs at reset values within same CLK; after release, first hsync pulse at normal offset from new line start.
